// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM encoding and buffer geometry for the keypad entry logic
package keypad_pkg;
  typedef enum logic [1:0] {IDLE, DB_PRESS, PRESSED, DB_RELEASE} state_t;
  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W = 4;
  localparam int CNT_W = 3;
  localparam int BUF_W = NUM_DIGITS * DIGIT_W;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: pulses stable once level has matched expected for DB_CYCLES consecutive cycles
module key_debounce #(
  parameter int DB_CYCLES = 20000,
  parameter int DB_W = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic level,
  input  logic expected,
  output logic stable
);
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic match, at_max;
  assign match = level == expected;
  assign at_max = cnt_q == DB_W'(DB_CYCLES - 1);
  assign stable = match && at_max;
  // Saturate rather than wrap so a long hold can never re-trigger
  always_comb cnt_d = (clr || !match) ? '0 : at_max ? cnt_q : cnt_q + DB_W'(1);
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/key_entry_buffer.sv
// key_entry_buffer: debounced keypad capture into a 4-digit shift buffer with strobe
module key_entry_buffer
  import keypad_pkg::*;
#(
  parameter int DB_CYCLES = 20000,
  parameter int DB_W = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               key_p,
  input  logic [DIGIT_W-1:0] hex_in,
  input  logic               clear,
  output logic [BUF_W-1:0]   digits,
  output logic [CNT_W-1:0]   digit_count,
  output logic               full,
  output logic               key_strobe,
  output logic [DIGIT_W-1:0] last_key
);
  state_t state_q, state_d;
  logic [BUF_W-1:0] digits_q, digits_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DIGIT_W-1:0] last_q, last_d;
  logic strobe_q, strobe_d;
  logic stable, accept, db_clr, db_exp;
  // Counter idles at zero outside the two debounce states
  assign db_clr = state_q == IDLE || state_q == PRESSED;
  assign db_exp = state_q == DB_PRESS;
  key_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db (
    .clock   (clock),
    .reset   (reset),
    .clr     (db_clr),
    .level   (key_p),
    .expected(db_exp),
    .stable  (stable)
  );
  always_comb begin
    state_d = state_q;
    accept = 1'b0;
    case (state_q)
      IDLE:       state_d = key_p ? DB_PRESS : IDLE;
      DB_PRESS: begin
        state_d = !key_p ? IDLE : stable ? PRESSED : DB_PRESS;
        accept = key_p && stable;
      end
      PRESSED:    state_d = key_p ? PRESSED : DB_RELEASE;
      DB_RELEASE: state_d = key_p ? PRESSED : stable ? IDLE : DB_RELEASE;
      default:    state_d = IDLE;
    endcase
  end
  // clear overrides a same-cycle acceptance; the FSM still advances
  always_comb begin
    digits_d = clear ? '0 : accept ? {digits_q[BUF_W-DIGIT_W-1:0], hex_in} : digits_q;
    count_d = clear ? '0 : (accept && count_q != CNT_W'(NUM_DIGITS)) ? count_q + CNT_W'(1) : count_q;
    last_d = (accept && !clear) ? hex_in : last_q;
    strobe_d = accept && !clear;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      digits_q <= '0;
      count_q <= '0;
      last_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      digits_q <= digits_d;
      count_q <= count_d;
      last_q <= last_d;
      strobe_q <= strobe_d;
    end
  end
  assign digits = digits_q;
  assign digit_count = count_q;
  assign full = count_q == CNT_W'(NUM_DIGITS);
  assign key_strobe = strobe_q;
  assign last_key = last_q;
endmodule

// File: tb/tb_key_entry_buffer.sv
// tb_key_entry_buffer: directed checks of debounce, buffering, clear and reset behaviour
module tb_key_entry_buffer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic key_p = 1'b0;
  logic [3:0] hex_in = 4'h0;
  logic clear = 1'b0;
  logic [15:0] digits;
  logic [2:0] digit_count;
  logic full, key_strobe;
  logic [3:0] last_key;
  int tests = 0;
  int fails = 0;
  int strobes = 0;
  key_entry_buffer #(.DB_CYCLES(4), .DB_W(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .key_p      (key_p),
    .hex_in     (hex_in),
    .clear      (clear),
    .digits     (digits),
    .digit_count(digit_count),
    .full       (full),
    .key_strobe (key_strobe),
    .last_key   (last_key)
  );
  always #5 clock = ~clock;
  always @(negedge clock) if (key_strobe) strobes++;
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic press(input logic [3:0] h, input int hold, input int rel);
    hex_in = h;
    key_p = 1'b1;
    tick(hold);
    key_p = 1'b0;
    tick(rel);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_digits"}, 32'(digits), 32'h0);
    chk({tag, "_count"}, 32'(digit_count), 32'h0);
    chk({tag, "_full"}, 32'(full), 32'h0);
    chk({tag, "_strobe"}, 32'(key_strobe), 32'h0);
    chk({tag, "_last"}, 32'(last_key), 32'h0);
  endtask
  initial begin
    tick(2);
    chk_zero("rst");
    reset = 1'b0;
    tick(1);
    // single press: strobe on the 5th edge after key_p rises
    strobes = 0;
    hex_in = 4'h5;
    key_p = 1'b1;
    tick(4);
    chk("lat_early", 32'(key_strobe), 32'h0);
    tick(1);
    chk("lat_strobe", 32'(key_strobe), 32'h1);
    chk("k5_digits", 32'(digits), 32'h0005);
    chk("k5_count", 32'(digit_count), 32'h1);
    chk("k5_last", 32'(last_key), 32'h5);
    tick(1);
    chk("strobe_1cyc", 32'(key_strobe), 32'h0);
    tick(4);
    key_p = 1'b0;
    tick(6);
    chk("k5_strobes", 32'(strobes), 32'h1);
    // fill and overflow
    strobes = 0;
    press(4'h1, 7, 7);
    press(4'h2, 7, 7);
    press(4'h3, 7, 7);
    chk("fill_full", 32'(full), 32'h1);
    press(4'h4, 7, 7);
    press(4'h9, 7, 7);
    chk("ovf_digits", 32'(digits), 32'h2349);
    chk("ovf_count", 32'(digit_count), 32'h4);
    chk("ovf_full", 32'(full), 32'h1);
    chk("ovf_last", 32'(last_key), 32'h9);
    chk("ovf_strobes", 32'(strobes), 32'h5);
    // short glitch is rejected
    strobes = 0;
    press(4'h8, 2, 3);
    chk("glitch_strobes", 32'(strobes), 32'h0);
    chk("glitch_digits", 32'(digits), 32'h2349);
    // release bounce must not re-accept
    hex_in = 4'h7;
    key_p = 1'b1;
    tick(6);
    key_p = 1'b0;
    tick(2);
    key_p = 1'b1;
    tick(4);
    key_p = 1'b0;
    tick(7);
    chk("bounce_strobes", 32'(strobes), 32'h1);
    chk("bounce_digits", 32'(digits), 32'h3497);
    // clear coincident with acceptance
    strobes = 0;
    hex_in = 4'hA;
    key_p = 1'b1;
    tick(4);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("clracc_strobe", 32'(key_strobe), 32'h0);
    chk("clracc_digits", 32'(digits), 32'h0);
    chk("clracc_count", 32'(digit_count), 32'h0);
    chk("clracc_full", 32'(full), 32'h0);
    tick(3);
    key_p = 1'b0;
    tick(7);
    chk("clracc_strobes", 32'(strobes), 32'h0);
    press(4'hB, 7, 7);
    chk("kB_digits", 32'(digits), 32'h000B);
    chk("kB_count", 32'(digit_count), 32'h1);
    chk("kB_strobes", 32'(strobes), 32'h1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("clr_digits", 32'(digits), 32'h0);
    chk("clr_last", 32'(last_key), 32'hB);
    // reset during DB_PRESS with key held
    strobes = 0;
    hex_in = 4'h6;
    key_p = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(1);
    chk_zero("rst_dbp");
    reset = 1'b0;
    tick(4);
    chk("rst_dbp_early", 32'(key_strobe), 32'h0);
    tick(1);
    chk("rst_dbp_strobe", 32'(key_strobe), 32'h1);
    chk("rst_dbp_digits", 32'(digits), 32'h0006);
    // reset during PRESSED with key held
    tick(2);
    reset = 1'b1;
    tick(1);
    chk_zero("rst_prs");
    reset = 1'b0;
    tick(4);
    chk("rst_prs_early", 32'(key_strobe), 32'h0);
    tick(1);
    chk("rst_prs_strobe", 32'(key_strobe), 32'h1);
    chk("rst_prs_count", 32'(digit_count), 32'h1);
    tick(3);
    key_p = 1'b0;
    tick(7);
    chk("rst_strobes", 32'(strobes), 32'h2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
